// File: rtl/exc_arbiter_pkg.sv
// rtl/exc_arbiter_pkg.sv - exception codes, FSM states and access-size helpers for exc_arbiter
package exc_arbiter_pkg;

  localparam int EXC_CODE_W = 5;
  localparam int CP0_INT_W  = 6;

  typedef logic [EXC_CODE_W-1:0] exc_code_t;

  localparam exc_code_t EXC_INT  = 5'h00;
  localparam exc_code_t EXC_ADEL = 5'h04;
  localparam exc_code_t EXC_ADES = 5'h05;
  localparam exc_code_t EXC_SYS  = 5'h08;
  localparam exc_code_t EXC_RI   = 5'h0a;
  localparam exc_code_t EXC_OV   = 5'h0c;
  localparam exc_code_t EXC_NONE = 5'h10;
  localparam exc_code_t EXC_ERET = 5'h11;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {ST_RUN, ST_HOLD} state_t;

  // Size code 3 is not a legal access and is never flagged.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return |addr_lo;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exc_arbiter_if.sv
// rtl/exc_arbiter_if.sv - MEM-stage inputs, CP0 state and registered exception record
interface exc_arbiter_if;
  import exc_arbiter_pkg::*;

  logic [CP0_INT_W-1:0] ext_int_i;
  logic                 stall_i;
  logic                 flush_i;
  logic                 mem_valid_i;
  logic [31:0]          mem_pc_i;
  logic                 mem_in_delay_i;
  exc_code_t            mem_exccode_i;
  logic                 mem_load_i;
  logic                 mem_store_i;
  logic [1:0]           mem_size_i;
  logic [31:0]          mem_addr_i;
  logic [31:0]          status_i;
  logic [31:0]          cause_i;
  logic [CP0_INT_W-1:0] int_o;
  logic                 mem_kill_o;
  exc_code_t            exccode_o;
  logic [31:0]          pc_o;
  logic                 in_delay_o;
  logic [31:0]          badvaddr_o;

  modport master (
    output ext_int_i, stall_i, flush_i, mem_valid_i, mem_pc_i, mem_in_delay_i, mem_exccode_i,
           mem_load_i, mem_store_i, mem_size_i, mem_addr_i, status_i, cause_i,
    input  int_o, mem_kill_o, exccode_o, pc_o, in_delay_o, badvaddr_o
  );

  modport slave (
    input  ext_int_i, stall_i, flush_i, mem_valid_i, mem_pc_i, mem_in_delay_i, mem_exccode_i,
           mem_load_i, mem_store_i, mem_size_i, mem_addr_i, status_i, cause_i,
    output int_o, mem_kill_o, exccode_o, pc_o, in_delay_o, badvaddr_o
  );

endinterface

// File: rtl/exc_arbiter_int_sync.sv
// rtl/exc_arbiter_int_sync.sv - two-flop synchroniser for asynchronous interrupt lines
module int_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/exc_arbiter.sv
// rtl/exc_arbiter.sv - MEM-stage exception arbiter producing the one-cycle CP0 exception record
module exc_arbiter
  import exc_arbiter_pkg::*;
#(
  parameter int HOLDOFF = 1
) (
  input logic          cpu_clk_50M,
  input logic          cpu_rst_n,
  exc_arbiter_if.slave bus
);

  localparam logic [2:0] HOLD_INIT = 3'(HOLDOFF - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       int_req, misalign, earlier_exc, has_cause, run, commit;
  exc_code_t  win_code;
  logic [31:0] bad_d;
  logic       unused_bits;

  int_sync #(.WIDTH(CP0_INT_W)) u_int_sync (
    .clk   (cpu_clk_50M),
    .rst_n (cpu_rst_n),
    .d     (bus.ext_int_i),
    .q     (bus.int_o)
  );

  assign int_req     = bus.status_i[0] & ~bus.status_i[1] & |(bus.cause_i[15:8] & bus.status_i[15:8]);
  assign misalign    = (bus.mem_load_i | bus.mem_store_i) & is_misaligned(bus.mem_size_i, bus.mem_addr_i[1:0]);
  assign earlier_exc = bus.mem_exccode_i != EXC_NONE;
  assign has_cause   = int_req | earlier_exc | misalign;
  assign run         = state_q == ST_RUN;
  assign commit      = bus.mem_valid_i & ~bus.stall_i & ~bus.flush_i & run;
  assign bus.mem_kill_o = bus.mem_valid_i & has_cause & run;
  assign unused_bits = &{1'b0, bus.status_i[31:16], bus.status_i[7:2], bus.cause_i[31:16], bus.cause_i[7:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (bus.flush_i) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        if (bus.flush_i) cnt_d = HOLD_INIT;
        else if (cnt_q == 3'd0) state_d = ST_RUN;
        else cnt_d = cnt_q - 3'd1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Interrupts outrank anything carried down the pipe; data misalign is the last resort.
  always_comb begin
    win_code = EXC_NONE;
    bad_d    = bus.badvaddr_o;
    if (int_req) begin
      win_code = EXC_INT;
    end else if (earlier_exc) begin
      win_code = bus.mem_exccode_i;
      if (bus.mem_exccode_i == EXC_ADEL) bad_d = bus.mem_pc_i;
    end else if (misalign) begin
      win_code = bus.mem_load_i ? EXC_ADEL : EXC_ADES;
      bad_d    = bus.mem_addr_i;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q        <= ST_RUN;
      cnt_q          <= 3'd0;
      bus.exccode_o  <= EXC_NONE;
      bus.pc_o       <= 32'd0;
      bus.in_delay_o <= 1'b0;
      bus.badvaddr_o <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit && has_cause) begin
        bus.exccode_o  <= win_code;
        bus.pc_o       <= bus.mem_pc_i;
        bus.in_delay_o <= bus.mem_in_delay_i;
        bus.badvaddr_o <= bad_d;
      end else begin
        bus.exccode_o  <= EXC_NONE;
      end
    end
  end

endmodule

// File: tb/tb_exc_arbiter.sv
// tb/tb_exc_arbiter.sv - scoreboard bench for exc_arbiter
module tb_exc_arbiter;
  import exc_arbiter_pkg::*;

  logic cpu_clk_50M = 1'b0;
  logic cpu_rst_n   = 1'b0;
  always #10 cpu_clk_50M = ~cpu_clk_50M;

  exc_arbiter_if bus ();

  exc_arbiter #(.HOLDOFF(2)) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .bus         (bus)
  );

  typedef struct {
    string       name;
    exc_code_t   code;
    logic [31:0] pc;
    logic [31:0] bad;
    logic        dly;
  } rec_t;

  rec_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_bad = 32'd0;

  task automatic idle();
    bus.ext_int_i      = '0;
    bus.stall_i        = 1'b0;
    bus.flush_i        = 1'b0;
    bus.mem_valid_i    = 1'b0;
    bus.mem_pc_i       = 32'd0;
    bus.mem_in_delay_i = 1'b0;
    bus.mem_exccode_i  = EXC_NONE;
    bus.mem_load_i     = 1'b0;
    bus.mem_store_i    = 1'b0;
    bus.mem_size_i     = SIZE_WORD;
    bus.mem_addr_i     = 32'd0;
    bus.status_i       = 32'h1000_0000;
    bus.cause_i        = 32'd0;
  endtask

  task automatic expect_rec(input string name, input exc_code_t code, input logic [31:0] pc,
                            input logic [31:0] bad, input logic dly);
    rec_t r;
    r.name = name; r.code = code; r.pc = pc; r.bad = bad; r.dly = dly;
    sb.push_back(r);
  endtask

  task automatic expect_none(input string name);
    expect_rec(name, EXC_NONE, 32'd0, 32'd0, 1'b0);
  endtask

  // Advance one edge and retire the oldest expected record against the DUT.
  task automatic tick();
    rec_t r;
    @(posedge cpu_clk_50M);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: record %h with nothing expected", bus.exccode_o);
    end else begin
      r = sb.pop_front();
      if (bus.exccode_o !== r.code) begin
        errors++;
        $display("FAIL %s exccode: got %h want %h", r.name, bus.exccode_o, r.code);
      end
      if (r.code != EXC_NONE) begin
        checks += 3;
        if (bus.pc_o !== r.pc) begin
          errors++;
          $display("FAIL %s pc: got %h want %h", r.name, bus.pc_o, r.pc);
        end
        if (bus.badvaddr_o !== r.bad) begin
          errors++;
          $display("FAIL %s badvaddr: got %h want %h", r.name, bus.badvaddr_o, r.bad);
        end
        if (bus.in_delay_o !== r.dly) begin
          errors++;
          $display("FAIL %s in_delay: got %b want %b", r.name, bus.in_delay_o, r.dly);
        end
      end
    end
  endtask

  task automatic test_reset();
    cpu_rst_n = 1'b0;
    idle();
    repeat (3) @(posedge cpu_clk_50M);
    #1;
    checks += 6;
    if (bus.int_o !== 6'd0) begin errors++; $display("FAIL rst int_o: got %h want 00", bus.int_o); end
    if (bus.exccode_o !== EXC_NONE) begin errors++; $display("FAIL rst exccode: got %h want 10", bus.exccode_o); end
    if (bus.pc_o !== 32'd0) begin errors++; $display("FAIL rst pc: got %h want 0", bus.pc_o); end
    if (bus.in_delay_o !== 1'b0) begin errors++; $display("FAIL rst in_delay: got %b want 0", bus.in_delay_o); end
    if (bus.badvaddr_o !== 32'd0) begin errors++; $display("FAIL rst badvaddr: got %h want 0", bus.badvaddr_o); end
    if (bus.mem_kill_o !== 1'b0) begin errors++; $display("FAIL rst kill: got %b want 0", bus.mem_kill_o); end
    cpu_rst_n = 1'b1;
    exp_bad = 32'd0;
    expect_none("post_rst");
    tick();
  endtask

  task automatic test_misalign();
    idle();
    bus.mem_valid_i = 1'b1; bus.mem_load_i = 1'b1; bus.mem_size_i = SIZE_WORD;
    bus.mem_addr_i = 32'h8000_0002; bus.mem_pc_i = 32'h8000_0040;
    #1; checks++;
    if (bus.mem_kill_o !== 1'b1) begin errors++; $display("FAIL lw_kill: got %b want 1", bus.mem_kill_o); end
    exp_bad = 32'h8000_0002;
    expect_rec("lw_adel", EXC_ADEL, 32'h8000_0040, exp_bad, 1'b0);
    tick();
    idle();
    expect_none("after_adel");
    tick();
    bus.mem_valid_i = 1'b1; bus.mem_load_i = 1'b1; bus.mem_size_i = SIZE_BYTE;
    bus.mem_addr_i = 32'h8000_0003; bus.mem_pc_i = 32'h8000_0044;
    #1; checks++;
    if (bus.mem_kill_o !== 1'b0) begin errors++; $display("FAIL lb_kill: got %b want 0", bus.mem_kill_o); end
    expect_none("lb_odd");
    tick();
    idle();
    bus.mem_valid_i = 1'b1; bus.mem_store_i = 1'b1; bus.mem_size_i = SIZE_HALF;
    bus.mem_addr_i = 32'h8000_1001; bus.mem_pc_i = 32'h8000_0048; bus.mem_in_delay_i = 1'b1;
    exp_bad = 32'h8000_1001;
    expect_rec("sh_ades", EXC_ADES, 32'h8000_0048, exp_bad, 1'b1);
    tick();
    bus.mem_size_i = SIZE_WORD; bus.mem_addr_i = 32'h8000_1004; bus.mem_in_delay_i = 1'b0;
    expect_none("sw_aligned");
    tick();
  endtask

  task automatic test_interrupt();
    idle();
    bus.ext_int_i = 6'b000100;
    expect_none("sync_1");
    tick();
    checks++;
    if (bus.int_o !== 6'b000000) begin errors++; $display("FAIL sync_lat1: got %b want 000000", bus.int_o); end
    expect_none("sync_2");
    tick();
    checks++;
    if (bus.int_o !== 6'b000100) begin errors++; $display("FAIL sync_lat2: got %b want 000100", bus.int_o); end
    bus.status_i = 32'h1000_1001; bus.cause_i = 32'h0000_1000;
    bus.mem_valid_i = 1'b1; bus.mem_pc_i = 32'h8000_0100; bus.mem_addr_i = 32'h0000_0100;
    #1; checks++;
    if (bus.mem_kill_o !== 1'b1) begin errors++; $display("FAIL int_kill: got %b want 1", bus.mem_kill_o); end
    expect_rec("int_take", EXC_INT, 32'h8000_0100, exp_bad, 1'b0);
    tick();
    bus.status_i = 32'h1000_1003;
    bus.mem_pc_i = 32'h8000_0104;
    #1; checks++;
    if (bus.mem_kill_o !== 1'b0) begin errors++; $display("FAIL exl_kill: got %b want 0", bus.mem_kill_o); end
    expect_none("int_exl_masked");
    tick();
  endtask

  task automatic test_pending();
    idle();
    bus.status_i = 32'h1000_1001; bus.cause_i = 32'h0000_1000;
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (bus.mem_kill_o !== 1'b0) begin errors++; $display("FAIL pend_kill%0d: got %b want 0", i, bus.mem_kill_o); end
      expect_none("pend_bubble");
      tick();
    end
    bus.mem_valid_i = 1'b1; bus.stall_i = 1'b1; bus.mem_pc_i = 32'h8000_01fc;
    expect_none("pend_stall");
    tick();
    bus.stall_i = 1'b0; bus.mem_pc_i = 32'h8000_0200;
    expect_rec("pend_fire", EXC_INT, 32'h8000_0200, exp_bad, 1'b0);
    tick();
  endtask

  task automatic test_priority();
    idle();
    bus.mem_valid_i = 1'b1; bus.mem_store_i = 1'b1; bus.mem_size_i = SIZE_HALF;
    bus.mem_addr_i = 32'h8000_2001; bus.mem_exccode_i = EXC_SYS; bus.mem_pc_i = 32'h8000_0300;
    expect_rec("sys_over_ades", EXC_SYS, 32'h8000_0300, exp_bad, 1'b0);
    tick();
    bus.status_i = 32'h1000_1001; bus.cause_i = 32'h0000_1000; bus.mem_pc_i = 32'h8000_0304;
    expect_rec("int_over_sys", EXC_INT, 32'h8000_0304, exp_bad, 1'b0);
    tick();
    idle();
    bus.mem_valid_i = 1'b1; bus.mem_exccode_i = EXC_ADEL; bus.mem_pc_i = 32'h8000_0306;
    exp_bad = 32'h8000_0306;
    expect_rec("ifetch_adel", EXC_ADEL, 32'h8000_0306, exp_bad, 1'b0);
    tick();
    idle();
    expect_none("prio_idle");
    tick();
  endtask

  task automatic test_flush();
    idle();
    bus.mem_valid_i = 1'b1; bus.mem_load_i = 1'b1; bus.mem_size_i = SIZE_WORD;
    bus.mem_addr_i = 32'h8000_3002; bus.mem_pc_i = 32'h8000_0400;
    bus.flush_i = 1'b1;
    expect_none("flush_wins");
    tick();
    bus.flush_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1; checks++;
      if (bus.mem_kill_o !== 1'b0) begin errors++; $display("FAIL hold_kill%0d: got %b want 0", i, bus.mem_kill_o); end
      expect_none("holdoff");
      tick();
    end
    #1; checks++;
    if (bus.mem_kill_o !== 1'b1) begin errors++; $display("FAIL run_kill: got %b want 1", bus.mem_kill_o); end
    exp_bad = 32'h8000_3002;
    expect_rec("after_hold", EXC_ADEL, 32'h8000_0400, exp_bad, 1'b0);
    tick();
    bus.flush_i = 1'b1; expect_none("reload_f1"); tick();
    bus.flush_i = 1'b0; expect_none("reload_h1"); tick();
    bus.flush_i = 1'b1; expect_none("reload_f2"); tick();
    bus.flush_i = 1'b0; expect_none("reload_h2"); tick();
    expect_none("reload_h3"); tick();
    expect_rec("after_reload", EXC_ADEL, 32'h8000_0400, exp_bad, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    bus.ext_int_i = 6'h3f; bus.status_i = 32'h1000_1001; bus.cause_i = 32'h0000_1000;
    expect_none("rm_sync1"); tick();
    expect_none("rm_sync2"); tick();
    bus.mem_valid_i = 1'b1; bus.mem_pc_i = 32'h8000_0500; bus.mem_in_delay_i = 1'b1;
    expect_rec("rm_rec", EXC_INT, 32'h8000_0500, exp_bad, 1'b1);
    tick();
    bus.stall_i = 1'b1;
    cpu_rst_n = 1'b0;
    #1;
    checks += 5;
    if (bus.exccode_o !== EXC_NONE) begin errors++; $display("FAIL arst exccode: got %h want 10", bus.exccode_o); end
    if (bus.pc_o !== 32'd0) begin errors++; $display("FAIL arst pc: got %h want 0", bus.pc_o); end
    if (bus.in_delay_o !== 1'b0) begin errors++; $display("FAIL arst in_delay: got %b want 0", bus.in_delay_o); end
    if (bus.badvaddr_o !== 32'd0) begin errors++; $display("FAIL arst badvaddr: got %h want 0", bus.badvaddr_o); end
    if (bus.int_o !== 6'd0) begin errors++; $display("FAIL arst int_o: got %h want 00", bus.int_o); end
    repeat (2) @(posedge cpu_clk_50M);
    #1;
    cpu_rst_n = 1'b1;
    exp_bad = 32'd0;
    expect_none("rel_stall1"); tick();
    expect_none("rel_stall2"); tick();
    bus.stall_i = 1'b0; bus.mem_valid_i = 1'b0;
    expect_none("rel_bubble"); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    test_reset();
    test_misalign();
    test_interrupt();
    test_pending();
    test_priority();
    test_flush();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d records want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
